bus_invert_tx: RTL



---
 rtl/bus_invert_popcount.sv | 30 +++
 rtl/bus_invert_tx.sv | 124 ++++++++++++
 2 files changed

// File: rtl/bus_invert_popcount.sv
// -----------------------------------------------------------------------------
// bus_invert_popcount
//   Combinational population count of a WIDTH-bit vector. Used by the
//   bus-invert transmitter to count toggling lines against the previous bus.
//
// Ports:
//   i_bits  [WIDTH-1:0]   input vector
//   o_count [CW-1:0]      number of set bits in i_bits, CW = clog2(WIDTH+1)
// -----------------------------------------------------------------------------
module bus_invert_popcount #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_bits,
  output logic [CW-1:0]    o_count
);

  logic [CW-1:0] w_sum;

  // Straight accumulation; synthesis rebalances this into an adder tree.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_sum = w_sum + CW'(i_bits[i]);
    end
  end

  assign o_count = w_sum;

endmodule

// File: rtl/bus_invert_tx.sv
// -----------------------------------------------------------------------------
// bus_invert_tx
//   Bus-invert (DBI) transmitter. Each word is driven either true or
//   complemented so that at most WIDTH/2 data lines toggle relative to the
//   previously driven word; dout_inv flags the complemented case. The receiver
//   recovers data as dout ^ {WIDTH{dout_inv}}.
//   Two-stage pipeline: stage A (input register) and stage B (output register),
//   full throughput with valid/ready handshakes on both sides.
//
// Ports:
//   clk        rising-edge clock
//   arst       asynchronous active-high reset
//   din        source word              din_valid   source word valid
//   din_ready  block accepts din this cycle (combinational from dout_ready)
//   dout       encoded bus value        dout_inv    1 = dout is complemented
//   dout_valid dout/dout_inv valid      dout_ready  sink consumes dout
//   inv_count  count of words issued with dout_inv=1 (wraps)
// -----------------------------------------------------------------------------
module bus_invert_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_inv,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] inv_count
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] HALF = CW'(WIDTH / 2);

  // Stage A
  logic [WIDTH-1:0] r_a_data;
  logic             r_a_valid;

  // Stage B
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_inv;
  logic             r_dout_valid;

  logic [CNT_W-1:0] r_inv_count;

  logic             w_adv_b;
  logic             w_adv_a;
  logic             w_in_xfer;
  logic             w_inv;
  logic [CW-1:0]    w_dist;
  logic [WIDTH-1:0] w_enc;

  // last_bus / last_inv are exactly the stage B contents: they are reset and
  // loaded together with dout/dout_inv, and dout is not cleared when stage B
  // merely empties, so the stage B registers double as the history.
  logic [WIDTH-1:0] w_last_bus;
  logic             w_last_inv;

  assign w_last_bus = r_dout;
  assign w_last_inv = r_dout_inv;

  // Flow control
  assign w_adv_b   = !r_dout_valid || dout_ready;
  assign w_adv_a   = r_a_valid && w_adv_b;
  assign din_ready = !arst && (!r_a_valid || w_adv_b);
  assign w_in_xfer = din_valid && din_ready;

  bus_invert_popcount #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .i_bits  (r_a_data ^ w_last_bus),
    .o_count (w_dist)
  );

  // Tie keeps the previous invert state so the side-band line does not toggle.
  always_comb begin
    w_inv = w_last_inv;
    if (w_dist > HALF) begin
      w_inv = 1'b1;
    end else if (w_dist < HALF) begin
      w_inv = 1'b0;
    end
    w_enc = r_a_data ^ {WIDTH{w_inv}};
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_a_data  <= '0;
      r_a_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_a_data  <= din;
      r_a_valid <= 1'b1;
    end else if (w_adv_a) begin
      r_a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_dout       <= '0;
      r_dout_inv   <= 1'b0;
      r_dout_valid <= 1'b0;
      r_inv_count  <= '0;
    end else if (w_adv_a) begin
      r_dout       <= w_enc;
      r_dout_inv   <= w_inv;
      r_dout_valid <= 1'b1;
      if (w_inv) begin
        r_inv_count <= r_inv_count + CNT_W'(1);
      end
    end else if (w_adv_b) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_inv   = r_dout_inv;
  assign dout_valid = r_dout_valid;
  assign inv_count  = r_inv_count;

endmodule
